vga_timing_gen: RTL and testbench

Pixel-timing generator for the 640x480@60 Hz display path. It runs on the pixel clock and produces the `DrawX`/`DrawY` coordinates and the `blank` display-enable that every sprite/ROM/palette drawing stage consumes. It also produces the `hs`/`vs` sync pulses, delayed so they line up with those stages' registered RGB output. Frame-boundary pulse and frame counter drive game-logic updates and sprite animation.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pixel-timing path.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Pixels per line including porches and sync.
  function automatic int h_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // Lines per frame including porches and sync.
  function automatic int v_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline for the hs/vs pair; resets to all-ones
// so the active-low syncs stay deasserted through reset.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int N = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  if (N == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [1:0] stage_q [N];

    // Shift the sync pair one stage per clock; reset forces every stage high.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < N; i++) stage_q[i] <= 2'b11;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: DrawX/DrawY counters, registered blank/sync/frame
// decodes aligned with the counters, delayed syncs and a frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  // Thresholds are 11 bits wide so a sync region ending exactly at 1024
  // still compares correctly against the 10-bit counters.
  localparam coord_t     H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t     V_LAST   = coord_t'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_C  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_C  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t     hc_q, hc_d;
  coord_t     vc_q, vc_d;
  logic       blank_q;
  logic       hs_raw_q;
  logic       vs_raw_q;
  logic       frame_end_q;
  logic [7:0] frame_count_q;
  logic [1:0] sync_dly;

  // Next counter values: hc wraps at H_TOTAL, vc advances only on that wrap.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  // Counters plus decodes of the next position, so each decode lands in the
  // same cycle as the DrawX/DrawY it describes.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b1;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      blank_q     <= ({1'b0, hc_d} < H_VIS_C) && ({1'b0, vc_d} < V_VIS_C);
      hs_raw_q    <= !(({1'b0, hc_d} >= HS_START) && ({1'b0, hc_d} < HS_END));
      vs_raw_q    <= !(({1'b0, vc_d} >= VS_START) && ({1'b0, vc_d} < VS_END));
      frame_end_q <= (hc_d == H_LAST) && (vc_d == V_LAST);
      if ((hc_q == H_LAST) && (vc_q == V_LAST)) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  sync_delay_line #(
    .N(SYNC_DELAY)
  ) u_sync_dly (
    .clk_i(vga_clk),
    .rst_i(reset),
    .d_i  ({hs_raw_q, vs_raw_q}),
    .q_o  (sync_dly)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign hs          = sync_dly[1];
  assign vs          = sync_dly[0];
  assign frame_end   = frame_end_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing at sync delays 0/1/3 for line-level checks,
// and a shrunken timing instance for frame-level and mid-frame reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d0_x, d0_y, d1_x, d1_y, d3_x, d3_y, sm_x, sm_y;
  logic       d0_b, d0_hs, d0_vs, d0_fe;
  logic       d1_b, d1_hs, d1_vs, d1_fe;
  logic       d3_b, d3_hs, d3_vs, d3_fe;
  logic       sm_b, sm_hs, sm_vs, sm_fe;
  logic [7:0] d0_fc, d1_fc, d3_fc, sm_fc;

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset(reset), .DrawX(d0_x), .DrawY(d0_y), .blank(d0_b),
    .hs(d0_hs), .vs(d0_vs), .frame_end(d0_fe), .frame_count(d0_fc));

  vga_timing_gen u_d1 (
    .vga_clk(clk), .reset(reset), .DrawX(d1_x), .DrawY(d1_y), .blank(d1_b),
    .hs(d1_hs), .vs(d1_vs), .frame_end(d1_fe), .frame_count(d1_fc));

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .vga_clk(clk), .reset(reset), .DrawX(d3_x), .DrawY(d3_y), .blank(d3_b),
    .hs(d3_hs), .vs(d3_vs), .frame_end(d3_fe), .frame_count(d3_fc));

  // 15 pixels x 8 lines: hsync at hc 10..12, vsync at vc 5..6, 120-cycle frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)
  ) u_sm (
    .vga_clk(clk), .reset(reset), .DrawX(sm_x), .DrawY(sm_y), .blank(sm_b),
    .hs(sm_hs), .vs(sm_vs), .frame_end(sm_fe), .frame_count(sm_fc));

  typedef struct {
    int k;
    int x;
    int y;
    bit b;
    bit h0;
    bit h1;
    bit h3;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int failures = 0;
  int k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  function automatic void add(input int kk, input int x, input int y, input bit b,
                              input bit h0, input bit h1, input bit h3);
    vec_t v;
    v.k = kk; v.x = x; v.y = y; v.b = b; v.h0 = h0; v.h1 = h1; v.h3 = h3;
    vt.push_back(v);
  endfunction

  initial begin
    int lo0, lo1, lo3, fx0, fx1, fx3;
    logic p0, p1, p3;
    int blank_cnt, vs_cnt, fe_f0, fe_seen, last_fe, gap_err, fc_err;

    // k = edges since reset release; expected values worked by hand.
    add(1,    1,   0, 1, 1, 1, 1);
    add(639,  639, 0, 1, 1, 1, 1);
    add(640,  640, 0, 0, 1, 1, 1);
    add(655,  655, 0, 0, 1, 1, 1);
    add(656,  656, 0, 0, 0, 1, 1);
    add(657,  657, 0, 0, 0, 0, 1);
    add(658,  658, 0, 0, 0, 0, 1);
    add(659,  659, 0, 0, 0, 0, 0);
    add(751,  751, 0, 0, 0, 0, 0);
    add(752,  752, 0, 0, 1, 0, 0);
    add(753,  753, 0, 0, 1, 1, 0);
    add(754,  754, 0, 0, 1, 1, 0);
    add(755,  755, 0, 0, 1, 1, 1);
    add(799,  799, 0, 0, 1, 1, 1);
    add(800,  0,   1, 1, 1, 1, 1);
    add(1439, 639, 1, 1, 1, 1, 1);
    add(1440, 640, 1, 0, 1, 1, 1);

    // Reset held 5 cycles.
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_drawx", d1_x, 0);
    chk("rst_drawy", d1_y, 0);
    chk("rst_blank", d1_b, 1);
    chk("rst_hs", d1_hs, 1);
    chk("rst_vs", d1_vs, 1);
    chk("rst_frame_end", d1_fe, 0);
    chk("rst_frame_count", d1_fc, 0);
    chk("rst_hs_d3", d3_hs, 1);
    chk("rst_hs_d0", d0_hs, 1);
    reset = 1'b0;
    k = 0;

    foreach (vt[i]) begin
      step_to(vt[i].k);
      chk("vec_drawx", d1_x, vt[i].x);
      chk("vec_drawy", d1_y, vt[i].y);
      chk("vec_blank", d1_b, vt[i].b);
      chk("vec_hs_d0", d0_hs, vt[i].h0);
      chk("vec_hs_d1", d1_hs, vt[i].h1);
      chk("vec_hs_d3", d3_hs, vt[i].h3);
      chk("vec_vs_d1", d1_vs, 1);
      chk("vec_frame_end", d1_fe, 0);
    end

    // One full line: hs low-run length and DrawX at each falling edge.
    lo0 = 0; lo1 = 0; lo3 = 0; fx0 = -1; fx1 = -1; fx3 = -1;
    p0 = d0_hs; p1 = d1_hs; p3 = d3_hs;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #1;
      k++;
      if (!d0_hs) lo0++;
      if (!d1_hs) lo1++;
      if (!d3_hs) lo3++;
      if (p0 && !d0_hs) fx0 = int'(d0_x);
      if (p1 && !d1_hs) fx1 = int'(d1_x);
      if (p3 && !d3_hs) fx3 = int'(d3_x);
      p0 = d0_hs; p1 = d1_hs; p3 = d3_hs;
    end
    chk("hs_low_len_d0", lo0, 96);
    chk("hs_low_len_d1", lo1, 96);
    chk("hs_low_len_d3", lo3, 96);
    chk("hs_fall_x_d0", fx0, 656);
    chk("hs_fall_x_d1", fx1, 657);
    chk("hs_fall_x_d3", fx3, 659);
    chk("line_fc_d1", d1_fc, 0);

    // Shrunken timing: fresh reset, then 257 frames of 120 cycles.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    blank_cnt = 0; vs_cnt = 0; fe_f0 = 0; fe_seen = 0;
    last_fe = -1; gap_err = 0; fc_err = 0;
    for (int n = 0; n <= 257 * 120; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (sm_fc !== 8'((n / 120) % 256)) fc_err++;
      if (n < 120) begin
        if (sm_b) blank_cnt++;
        if (!sm_vs) vs_cnt++;
        if (sm_fe) fe_f0++;
      end
      if (sm_fe) begin
        if (n % 120 != 119) gap_err++;
        if (last_fe >= 0 && n - last_fe != 120) gap_err++;
        last_fe = n;
        fe_seen++;
      end
      if (n == 76) begin
        chk("sm_vs_start_low", sm_vs, 0);
        chk("sm_vs_start_y", sm_y, 5);
        chk("sm_vs_start_x", sm_x, 1);
      end
      if (n == 119) begin
        chk("sm_fe_x", sm_x, 14);
        chk("sm_fe_y", sm_y, 7);
        chk("sm_fe_pulse", sm_fe, 1);
      end
      if (n == 120) chk("sm_fc_first", sm_fc, 1);
      if (n == 256 * 120 - 1) chk("sm_fc_255", sm_fc, 255);
      if (n == 256 * 120) chk("sm_fc_wrap0", sm_fc, 0);
    end
    chk("sm_blank_cnt", blank_cnt, 32);
    chk("sm_vs_low_cnt", vs_cnt, 30);
    chk("sm_fe_per_frame", fe_f0, 1);
    chk("sm_fe_total", fe_seen, 257);
    chk("sm_fe_spacing_err", gap_err, 0);
    chk("sm_fc_track_err", fc_err, 0);

    // Mid-frame reset inside both sync pulses at (12, 6).
    repeat (102) @(posedge clk);
    #1;
    chk("mid_x", sm_x, 12);
    chk("mid_y", sm_y, 6);
    chk("mid_hs", sm_hs, 0);
    chk("mid_vs", sm_vs, 0);
    chk("mid_fc", sm_fc, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_x", sm_x, 0);
    chk("mrst_y", sm_y, 0);
    chk("mrst_blank", sm_b, 1);
    chk("mrst_hs", sm_hs, 1);
    chk("mrst_vs", sm_vs, 1);
    chk("mrst_fe", sm_fe, 0);
    chk("mrst_fc", sm_fc, 0);
    chk("mrst_d3_hs", d3_hs, 1);
    chk("mrst_d3_vs", d3_vs, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_x", sm_x, 1);
    chk("rel_y", sm_y, 0);
    chk("rel_hs", sm_hs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
